// File: rtl/pattern_matcher_pkg.sv
// Shared types and constants for the serial pattern matcher.
//   state_t : FSM state encoding exposed on the state output
//   STATE_W : width of the state output
package pattern_matcher_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_matcher_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment yields 1, not 0.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear
//   inc        : increment request
//   count      : registered count, saturates at all-ones
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pattern_matcher.sv
// Serial bit-pattern matcher with overlap/restart modes, one-shot stop and
// a saturating match counter.
//   clk, rst_n   : clock, async active-low reset
//   cfg_we       : load cfg_pattern and arm the search (enters HUNT)
//   cfg_pattern  : pattern, MSB is the first bit expected on in
//   oneshot      : stop in DONE after the first match
//   in_valid, in : serial data, sampled only when in_valid is high
//   clr_cnt      : synchronous clear of match_cnt
//   match        : one-cycle pulse, one cycle after the completing bit
//   match_cnt    : saturating match count
//   state        : FSM state (IDLE=0, HUNT=1, DONE=2)
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               oneshot,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_q;
    logic               hit;
    logic [PAT_LEN-1:0] shifted;
    logic [FILL_W-1:0]  fill_inc;

    // State, pattern, history and match pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= hit;
        end
    end

    // Next-state, shift/fill update and match detection
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        hit       = 1'b0;
        shifted   = {hist_q[PAT_LEN-2:0], in};
        fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

        if (cfg_we) begin
            // Arming wins over any data bit in the same cycle
            pattern_d = cfg_pattern;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = HUNT;
        end else begin
            case (state_q)
                IDLE: ;
                HUNT: begin
                    if (in_valid) begin
                        hist_d = shifted;
                        fill_d = fill_inc;
                        if ((fill_inc == FILL_MAX) && (shifted == pattern_q)) begin
                            hit = 1'b1;
                            if (OVERLAP == 0) begin
                                fill_d = '0;
                            end
                            if (oneshot) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (hit),
        .count (match_cnt)
    );

    assign match = match_q;
    assign state = state_q;

endmodule

// File: tb/tb_pattern_matcher.sv
// Randomized + directed bench for pattern_matcher. Two instances share the
// stimulus: u_a (PAT_LEN=5, overlap, CNT_W=8) and u_b (PAT_LEN=3, restart,
// CNT_W=2, uses the low 3 pattern bits). A window-of-recent-bits model
// predicts every output each cycle.
`timescale 1ns/1ps
module tb_pattern_matcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic       oneshot;
    logic       in_valid;
    logic       in;
    logic       clr_cnt;

    logic       match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] state_a, state_b;

    int vectors = 0;
    int miscompares = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clk = ~clk;

    pattern_matcher #(.PAT_LEN(5), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .oneshot(oneshot), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
        .match(match_a), .match_cnt(cnt_a), .state(state_a));

    pattern_matcher #(.PAT_LEN(3), .OVERLAP(0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern[2:0]),
        .oneshot(oneshot), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
        .match(match_b), .match_cnt(cnt_b), .state(state_b));

    // Reference model: per instance, the bits accepted since arming (or since
    // the last match in restart mode), oldest first.
    int          m_state [2];
    int          m_cnt   [2];
    bit          m_match [2];
    logic [31:0] m_pat   [2];
    bit          win_a[$];
    bit          win_b[$];

    function automatic bit window_hit(input bit w[$], input int len, input logic [31:0] pat);
        if (w.size() != len) return 1'b0;
        for (int i = 0; i < len; i++)
            if (w[i] != pat[len-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int len, cmax;
            bit ov, hit;
            bit w[$];
            len  = (k == 0) ? 5 : 3;
            cmax = (k == 0) ? 255 : 3;
            ov   = (k == 0);
            w    = (k == 0) ? win_a : win_b;
            hit  = 1'b0;
            if (!rst_n) begin
                m_state[k] = 0; m_cnt[k] = 0; m_match[k] = 1'b0; m_pat[k] = 0;
                w.delete();
            end else begin
                if (cfg_we) begin
                    m_pat[k]   = (k == 0) ? {27'd0, cfg_pattern} : {29'd0, cfg_pattern[2:0]};
                    m_state[k] = 1;
                    w.delete();
                end else if (m_state[k] == 1 && in_valid) begin
                    w.push_back(in);
                    if (w.size() > len) void'(w.pop_front());
                    if (window_hit(w, len, m_pat[k])) begin
                        hit = 1'b1;
                        if (!ov) w.delete();
                        if (oneshot) m_state[k] = 2;
                    end
                end
                m_match[k] = hit;
                if (clr_cnt) m_cnt[k] = hit ? 1 : 0;
                else if (hit && m_cnt[k] < cmax) m_cnt[k]++;
            end
            if (k == 0) win_a = w; else win_b = w;
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, then compare.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("match_a", 32'(match_a), 32'(m_match[0]));
        check("cnt_a",   32'(cnt_a),   m_cnt[0]);
        check("state_a", 32'(state_a), m_state[0]);
        check("match_b", 32'(match_b), 32'(m_match[1]));
        check("cnt_b",   32'(cnt_b),   m_cnt[1]);
        check("state_b", 32'(state_b), m_state[1]);
        pulses_a += int'(match_a);
        pulses_b += int'(match_b);
    endtask

    task automatic arm(input logic [4:0] pat, input logic os);
        cfg_pattern = pat; oneshot = os; cfg_we = 1'b1; in_valid = 1'b0;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in = bits[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; oneshot = 1'b0;
        in_valid = 1'b0; in = 1'b0; clr_cnt = 1'b0;
        #1;
        check("rst_state", 32'(state_a), 0);
        check("rst_cnt",   32'(cnt_a),   0);
        check("rst_match", 32'(match_a), 0);
        step(); step();
        rst_n = 1'b1;

        // Idle: bits ignored
        send_bits(32'b10011, 5);
        check("idle_no_match", 32'(pulses_a), 0);

        // Basic 10011 match on u_a
        arm(5'b10011, 1'b0);
        pulses_a = 0;
        send_bits(32'b1001, 4);
        in = 1'b1; in_valid = 1'b1; step(); in_valid = 1'b0;
        check("basic_pulse_now", 32'(match_a), 1);
        check("basic_cnt", 32'(cnt_a), 1);
        idle_step();
        check("basic_pulse_gone", 32'(match_a), 0);
        check("basic_pulse_total", 32'(pulses_a), 1);

        // Overlap on u_a (10101 in 1010101 -> 2), restart on u_b (101 in 10101 -> 1)
        arm(5'b10101, 1'b0);
        pulses_a = 0; pulses_b = 0;
        send_bits(32'b10101, 5);
        check("restart_pulses_b", 32'(pulses_b), 1);
        send_bits(32'b01, 2);
        check("overlap_pulses_a", 32'(pulses_a), 2);

        // One-shot on u_b: 101101 -> one pulse then DONE
        arm(5'b00101, 1'b1);
        pulses_b = 0;
        send_bits(32'b101101, 6);
        check("oneshot_pulses", 32'(pulses_b), 1);
        check("oneshot_done", 32'(state_b), 2);
        send_bits(32'b101, 3);
        check("done_ignores", 32'(pulses_b), 1);
        arm(5'b00101, 1'b0);
        check("rearm_hunt", 32'(state_b), 1);
        send_bits(32'b101, 3);
        check("rearm_resumes", 32'(pulses_b), 2);

        // Saturation of the 2-bit counter, then clear coincident with a match
        clr_cnt = 1'b1; idle_step(); clr_cnt = 1'b0;
        for (int g = 0; g < 5; g++) begin
            send_bits(32'b101, 3);
            check("sat_cnt", 32'(cnt_b), (g < 3) ? g + 1 : 3);
        end
        send_bits(32'b10, 2);
        clr_cnt = 1'b1; in = 1'b1; in_valid = 1'b1; step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        check("clr_with_match", 32'(cnt_b), 1);

        // Reset mid-pattern discards the partial match
        arm(5'b10011, 1'b0);
        pulses_a = 0;
        send_bits(32'b1001, 4);
        rst_n = 1'b0; idle_step(); rst_n = 1'b1;
        arm(5'b10011, 1'b0);
        send_bits(32'b1, 1);
        check("rst_discard", 32'(pulses_a), 0);

        // Gaps inside a valid pattern still give a single match
        arm(5'b10011, 1'b0);
        pulses_a = 0;
        for (int i = 4; i >= 0; i--) begin
            in = cfg_pattern[i]; in_valid = 1'b1; step();
            in_valid = 1'b0; step(); step();
        end
        check("gap_single_match", 32'(pulses_a), 1);

        // Randomized traffic
        arm(5'($urandom), 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            cfg_we      = ($urandom_range(0, 59) == 0);
            cfg_pattern = 5'($urandom);
            if ($urandom_range(0, 99) == 0) oneshot = ~oneshot;
            in_valid    = ($urandom_range(0, 3) != 0);
            in          = 1'($urandom);
            clr_cnt     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 5, giving the pattern length in bits (legal 2..32).
REQ-002 The block SHALL have parameter OVERLAP, default 1: 1 allows overlapping matches, 0 restarts the search after each match.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 CFG_WE  input  1  load CFG_PATTERN and arm the search.
REQ-007 CFG_PATTERN  input  PAT_LEN  pattern; the MSB is the first bit expected on IN.
REQ-008 ONESHOT  input  1  stop searching after the first match.
REQ-009 IN_VALID  input  1  IN is sampled only when this is high.
REQ-010 IN  input  1  serial data bit.
REQ-011 CLR_CNT  input  1  synchronous clear of MATCH_CNT.
REQ-012 MATCH  output  1  registered one-cycle match pulse.
REQ-013 MATCH_CNT  output  CNT_W  saturating count of matches.
REQ-014 STATE  output  2  FSM state: IDLE=0, HUNT=1, DONE=2.

Function
REQ-015 The FSM SHALL have three states: IDLE (no pattern loaded), HUNT (searching) and DONE (one-shot hit); encoding 3 SHALL return to IDLE on the next edge.
REQ-016 CFG_WE SHALL, from any state, register the pattern, clear the history and fill count, and enter HUNT on that edge; an IN_VALID bit in the same cycle SHALL be discarded.
REQ-017 In HUNT, each IN_VALID=1 edge SHALL shift IN into the history register at the LSB and increment the fill count, saturating at PAT_LEN.
REQ-018 A match SHALL occur on an accepting edge when the fill count after the shift equals PAT_LEN and the history after the shift equals the loaded pattern.
REQ-019 MATCH SHALL be high for exactly the one cycle following the edge that accepted the final pattern bit (1-cycle latency) and low otherwise.
REQ-020 With OVERLAP=1, the history and fill count SHALL be kept after a match, so overlapping occurrences each pulse MATCH.
REQ-021 With OVERLAP=0, the fill count SHALL be cleared to 0 on the match edge.
REQ-022 IN_VALID=0 SHALL hold the history, the fill count and the FSM state unchanged.
REQ-023 A match with ONESHOT=1 SHALL move the FSM from HUNT to DONE on the match edge.
REQ-024 In DONE, IN SHALL be ignored and MATCH SHALL stay low; only CFG_WE or reset SHALL leave DONE.
REQ-025 In IDLE, IN SHALL be ignored and no match SHALL occur.
REQ-026 MATCH_CNT SHALL increment on each match edge and saturate at 2^CNT_W-1.
REQ-027 CLR_CNT SHALL set MATCH_CNT to 0; if a match occurs on the same edge, MATCH_CNT SHALL become 1.
REQ-028 CFG_WE SHALL NOT clear MATCH_CNT.

Reset
REQ-029 RST_N low SHALL immediately force STATE=IDLE, MATCH=0, MATCH_CNT=0, the history to 0, the fill count to 0 and the pattern register to 0.
REQ-030 RST_N asserted mid-search SHALL discard any partial match; a pattern completed in the first cycle after release SHALL NOT pulse MATCH, because the block is in IDLE.

Structure
REQ-031 A package pattern_matcher_pkg SHALL hold the state enum (IDLE, HUNT, DONE) and the STATE width constant.
REQ-032 The saturating counter SHALL be a sub-module sat_counter, parameterised by width, with clear-plus-increment semantics as in REQ-027.
REQ-033 The fill counter width SHALL be $clog2(PAT_LEN+1).

Verification
REQ-034 PAT_LEN=5, pattern 10011, ONESHOT=0: stream 1,0,0,1,1 -> MATCH pulses once, one cycle after the 5th bit; MATCH_CNT=1.
REQ-035 PAT_LEN=3, pattern 101: stream 1,0,1,0,1 -> OVERLAP=1 gives 2 pulses (after bits 3 and 5); OVERLAP=0 gives 1 pulse.
REQ-036 ONESHOT=1, pattern 101: stream 101101 -> 1 pulse and STATE=2 thereafter; a following CFG_WE -> STATE=1 and matching resumes.
REQ-037 CNT_W=2: 5 matches -> MATCH_CNT reads 1,2,3,3,3; CLR_CNT coincident with a 6th match -> MATCH_CNT=1.
REQ-038 Stream 1,0,0,1 then RST_N low for 1 cycle, then CFG_WE, then 1 -> no MATCH; IN_VALID gaps inserted inside a valid pattern -> single correct MATCH.
